// File: rtl/uart_controller_if.sv
// Serial receive line plus the received-byte output of the UART receiver.
// master is the receiver side; slave is the transmitter/consumer side.
interface uart_controller_if;
   logic       Rx;
   logic [7:0] data;
   logic       ready;

   modport master (input Rx, output data, output ready);
   modport slave  (output Rx, input data, input ready);
endinterface

// File: rtl/uart_controller.sv
// 8N1 UART receiver: synchronizes Rx, samples each bit at its centre and
// emits a one-cycle ready pulse with the received byte on data.
module uart_controller #(
   parameter int unsigned CLK_FREQ = 50000000,
   parameter int unsigned BAUD     = 115200
) (
   input  logic              clk50,
   input  logic              nreset,
   uart_controller_if.master bus
);

   localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD;
   localparam int unsigned HALF_BIT     = CLKS_PER_BIT / 2;
   localparam int unsigned CNT_W        = $clog2(CLKS_PER_BIT);

   typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} state_t;

   state_t             state;
   state_t             stateNext;
   logic               rxMeta;
   logic               rxs;
   logic [CNT_W-1:0]   cycleCount;
   logic [CNT_W-1:0]   countNext;
   logic [2:0]         bitIndex;
   logic [2:0]         indexNext;
   logic [7:0]         shiftReg;
   logic [7:0]         shiftNext;
   logic [7:0]         dataNext;
   logic               readyNext;
   logic               midStart;
   logic               bitDone;

   assign midStart = (cycleCount == CNT_W'(HALF_BIT - 1));
   assign bitDone  = (cycleCount == CNT_W'(CLKS_PER_BIT - 1));

   // Two-flop synchronizer, reset to the idle (high) line level
   always_ff @(posedge clk50 or negedge nreset) begin
      if (!nreset) begin
         rxMeta <= 1'b1;
         rxs    <= 1'b1;
      end else begin
         rxMeta <= bus.Rx;
         rxs    <= rxMeta;
      end
   end

   // State and datapath registers
   always_ff @(posedge clk50 or negedge nreset) begin
      if (!nreset) begin
         state      <= IDLE;
         cycleCount <= '0;
         bitIndex   <= '0;
         shiftReg   <= '0;
         bus.data   <= '0;
         bus.ready  <= 1'b0;
      end else begin
         state      <= stateNext;
         cycleCount <= countNext;
         bitIndex   <= indexNext;
         shiftReg   <= shiftNext;
         bus.data   <= dataNext;
         bus.ready  <= readyNext;
      end
   end

   // Next-state logic; a framing error parks in WAIT_IDLE until the line is high
   always_comb begin
      stateNext = state;
      unique case (state)
         IDLE:      if (!rxs) stateNext = START;
         START:     if (midStart) stateNext = rxs ? IDLE : DATA;
         DATA:      if (bitDone && (bitIndex == 3'd7)) stateNext = STOP;
         STOP:      if (bitDone) stateNext = rxs ? IDLE : WAIT_IDLE;
         WAIT_IDLE: if (rxs) stateNext = IDLE;
         default:   stateNext = IDLE;
      endcase
   end

   // Datapath and output next values
   always_comb begin
      countNext = cycleCount + CNT_W'(1);
      indexNext = bitIndex;
      shiftNext = shiftReg;
      dataNext  = bus.data;
      readyNext = 1'b0;
      unique case (state)
         IDLE, WAIT_IDLE: countNext = '0;
         START: begin
            if (midStart) begin
               countNext = '0;
               indexNext = '0;
            end
         end
         DATA: begin
            if (bitDone) begin
               countNext           = '0;
               shiftNext[bitIndex] = rxs;
               indexNext           = bitIndex + 3'd1;
            end
         end
         STOP: begin
            if (bitDone) begin
               countNext = '0;
               if (rxs) begin
                  dataNext  = shiftReg;
                  readyNext = 1'b1;
               end
            end
         end
         default: countNext = '0;
      endcase
   end

endmodule

// File: tb/tb_uart_controller.sv
// Scoreboard bench for uart_controller: stimulus pushes expected bytes,
// a negedge monitor pops and checks them on every ready pulse.
module tb_uart_controller;

   localparam int unsigned BIT_CLKS = 434;
   localparam int          NOM_LAT  = 4126;

   logic clk50;
   logic nreset;
   int unsigned cycle;
   int errors;
   int checks;
   int readyCount;

   logic [7:0]  expData[$];
   int unsigned expStart[$];

   uart_controller_if uif();

   uart_controller dut (
      .clk50  (clk50),
      .nreset (nreset),
      .bus    (uif)
   );

   initial begin
      clk50 = 1'b0;
      forever #10 clk50 = ~clk50;
   end

   initial begin
      cycle = 0;
      forever begin
         @(posedge clk50);
         cycle = cycle + 1;
      end
   end

   task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks = checks + 1;
      if (act !== exp) begin
         errors = errors + 1;
         $display("FAIL %s: got %02h expected %02h (cycle %0d)", name, act, exp, cycle);
      end
   endtask

   task automatic checkInt(input string name, input int act, input int exp);
      checks = checks + 1;
      if (act != exp) begin
         errors = errors + 1;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cycle);
      end
   endtask

   // Monitor: pulse width, unsolicited data changes and scoreboard pops
   initial begin
      logic       prevReady;
      logic [7:0] prevData;
      logic [7:0] eb;
      int         lat;
      prevReady = 1'b0;
      prevData  = 8'h00;
      forever begin
         @(negedge clk50);
         if (nreset) begin
            if (uif.ready === 1'b1) begin
               readyCount = readyCount + 1;
               if (prevReady) begin
                  checks = checks + 1;
                  errors = errors + 1;
                  $display("FAIL readyWidth: ready high two cycles at cycle %0d", cycle);
               end
               if (expData.size() == 0) begin
                  checks = checks + 1;
                  errors = errors + 1;
                  $display("FAIL extraReady: unexpected pulse data=%02h at cycle %0d", uif.data, cycle);
               end else begin
                  eb  = expData.pop_front();
                  lat = int'(cycle - expStart.pop_front());
                  check8("rxData", uif.data, eb);
                  checks = checks + 1;
                  if (lat < NOM_LAT - 2 || lat > NOM_LAT + 2) begin
                     errors = errors + 1;
                     $display("FAIL latency: got %0d cycles expected %0d +-2", lat, NOM_LAT);
                  end
               end
            end else if (uif.data !== prevData) begin
               checks = checks + 1;
               errors = errors + 1;
               $display("FAIL dataChange: data %02h -> %02h without ready at cycle %0d",
                        prevData, uif.data, cycle);
            end
         end
         prevReady = uif.ready;
         prevData  = uif.data;
      end
   end

   task automatic driveBit(input logic v, input int n);
      uif.Rx = v;
      repeat (n) @(negedge clk50);
   endtask

   // Full 10-bit frame; called at a negedge, leaves at a negedge
   task automatic sendByte(input logic [7:0] b, input int period, input logic stopBit);
      if (stopBit) begin
         expData.push_back(b);
         expStart.push_back(cycle);
      end
      driveBit(1'b0, period);
      for (int i = 0; i < 8; i++) driveBit(b[i], period);
      driveBit(stopBit, period);
   endtask

   task automatic waitDrain(input string name, input int maxCycles);
      int n;
      n = 0;
      while (expData.size() != 0 && n < maxCycles) begin
         @(negedge clk50);
         n = n + 1;
      end
      checks = checks + 1;
      if (expData.size() != 0) begin
         errors = errors + 1;
         $display("FAIL %s: %0d expected pulses still pending", name, expData.size());
         expData.delete();
         expStart.delete();
      end
   endtask

   initial begin
      repeat (95000) @(posedge clk50);
      $display("FAIL watchdog: simulation exceeded cycle budget");
      $fatal(1, "watchdog");
   end

   initial begin
      int rc;
      errors     = 0;
      checks     = 0;
      readyCount = 0;
      uif.Rx     = 1'b1;
      nreset     = 1'b0;
      repeat (5) @(negedge clk50);
      check8("resetData", uif.data, 8'h00);
      checkInt("resetReady", int'(uif.ready), 0);
      nreset = 1'b1;
      repeat (10) @(negedge clk50);

      // First frame, with data still zero well into the frame
      fork
         sendByte(8'hAA, BIT_CLKS, 1'b1);
         begin
            repeat (4000) @(negedge clk50);
            check8("preData", uif.data, 8'h00);
         end
      join
      waitDrain("drainAA", 2000);

      // Back-to-back frames
      rc = readyCount;
      sendByte(8'h55, BIT_CLKS, 1'b1);
      sendByte(8'h00, BIT_CLKS, 1'b1);
      sendByte(8'hFF, BIT_CLKS, 1'b1);
      waitDrain("drainB2B", 2000);
      checkInt("b2bCount", readyCount - rc, 3);

      // Short low glitch
      rc = readyCount;
      driveBit(1'b0, 100);
      driveBit(1'b1, 3000);
      checkInt("glitchNoReady", readyCount - rc, 0);
      check8("glitchData", uif.data, 8'hFF);

      // Framing error followed by a long break, then a good frame
      rc = readyCount;
      sendByte(8'h3C, BIT_CLKS, 1'b0);
      driveBit(1'b0, 2 * BIT_CLKS);
      driveBit(1'b1, BIT_CLKS);
      checkInt("framingNoReady", readyCount - rc, 0);
      check8("framingData", uif.data, 8'hFF);
      sendByte(8'hC3, BIT_CLKS, 1'b1);
      waitDrain("drainC3", 2000);

      // Reset in the middle of 0x81's data bits
      driveBit(1'b0, BIT_CLKS);
      driveBit(1'b1, BIT_CLKS);
      driveBit(1'b0, BIT_CLKS);
      driveBit(1'b0, 200);
      nreset = 1'b0;
      repeat (3) @(negedge clk50);
      check8("midResetData", uif.data, 8'h00);
      checkInt("midResetReady", int'(uif.ready), 0);
      uif.Rx = 1'b1;
      repeat (5) @(negedge clk50);
      nreset = 1'b1;
      repeat (20) @(negedge clk50);
      rc = readyCount;
      sendByte(8'h7E, BIT_CLKS, 1'b1);
      waitDrain("drain7E", 2000);
      checkInt("afterResetCount", readyCount - rc, 1);

      // Baud +2% and -2%
      sendByte(8'hA5, 425, 1'b1);
      waitDrain("drainFast", 2000);
      driveBit(1'b1, BIT_CLKS);
      sendByte(8'hA5, 443, 1'b1);
      waitDrain("drainSlow", 2000);
      check8("finalData", uif.data, 8'hA5);

      repeat (100) @(negedge clk50);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
